// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
//
// Run-control clock-enable sequencer. It divides clk into DIVISOR-cycle phase
// ticks and groups PHASES ticks into one CPU cycle. On the ticks of the chosen
// phases it emits one-cycle cpu_en / mem_en strobes in place of gated clocks.
// Run control covers free-run, single-step, N-cycle burst and sticky halt.
// Every stop decision is taken at the end of a CPU cycle, so a stop always
// leaves phase at 0.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   hlt          halt request (level), honoured at the end of a CPU cycle
//   run          free-run enable (level)
//   step         single CPU-cycle request
//   burst_start  start a burst of burst_len CPU cycles (0 is ignored)
//   burst_len    burst length, sampled with burst_start
//   cpu_en       one-cycle core clock enable
//   mem_en       one-cycle memory/IO clock enable
//   phase        current phase index
//   busy         sequencer is in RUN, STEP or BURST
//   halted       sequencer is in HALT
//   cycle_count  completed CPU cycles, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module phase_sequencer #(
  parameter  int DIVISOR   = 2,
  parameter  int PHASES    = 2,
  parameter  int CPU_PHASE = 0,
  parameter  int MEM_PHASE = 1,
  parameter  int CNT_W     = 32,
  localparam int PHASE_W   = (PHASES > 2) ? $clog2(PHASES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hlt,
  input  logic               run,
  input  logic               step,
  input  logic               burst_start,
  input  logic [CNT_W-1:0]   burst_len,
  output logic               cpu_en,
  output logic               mem_en,
  output logic [PHASE_W-1:0] phase,
  output logic               busy,
  output logic               halted,
  output logic [CNT_W-1:0]   cycle_count
);

  localparam int DIV_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(DIVISOR - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PHASES - 1);
  localparam logic [PHASE_W-1:0] CPU_PH     = PHASE_W'(CPU_PHASE);
  localparam logic [PHASE_W-1:0] MEM_PH     = PHASE_W'(MEM_PHASE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_BURST,
    S_HALT
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   remaining_q;
  logic               tick, wrap;
  logic               stay_busy;
  logic               load_burst;

  assign busy   = (state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_BURST);
  assign halted = (state_q == S_HALT);

  assign tick = busy && (div_q == DIV_LAST);
  // End of a CPU cycle: the only point where a busy state may be left.
  assign wrap = tick && (phase == PHASE_LAST);

  // Next-state logic.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    load_burst = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (hlt) begin
          state_d = S_HALT;
        end else if (burst_start && (burst_len != '0)) begin
          state_d    = S_BURST;
          load_burst = 1'b1;
        end else if (step) begin
          state_d = S_STEP;
        end else if (run) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (wrap) begin
          if (hlt)       state_d = S_HALT;
          else if (!run) state_d = S_IDLE;
        end
      end
      S_STEP: begin
        if (wrap) state_d = hlt ? S_HALT : S_IDLE;
      end
      S_BURST: begin
        if (wrap) begin
          if (hlt)                             state_d = S_HALT;
          else if (remaining_q == CNT_W'(1))   state_d = S_IDLE;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // The divider only runs while the sequencer stays busy; entering a busy
  // state from IDLE, or leaving one, always restarts it at 0.
  assign stay_busy = busy && (state_d != S_IDLE) && (state_d != S_HALT);

  always_comb begin
    div_d = '0;
    if (stay_busy) div_d = tick ? '0 : div_q + DIV_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      phase       <= '0;
      remaining_q <= '0;
      cpu_en      <= 1'b0;
      mem_en      <= 1'b0;
      cycle_count <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      // Strobes mark the phase that the current tick completes.
      cpu_en  <= tick && (phase == CPU_PH);
      mem_en  <= tick && (phase == MEM_PH);
      if (tick) phase <= (phase == PHASE_LAST) ? '0 : phase + PHASE_W'(1);
      if (wrap) cycle_count <= cycle_count + CNT_W'(1);
      if (load_burst)                      remaining_q <= burst_len;
      else if (wrap && state_q == S_BURST) remaining_q <= remaining_q - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_phase_sequencer
//
// Two instances share one clock:
//   a: default parameters (DIVISOR=2, PHASES=2, CPU_PHASE=0, MEM_PHASE=1)
//   b: DIVISOR=3, PHASES=4, CPU_PHASE=0, MEM_PHASE=2, CNT_W=4
// Instance a is driven from a vector table; instance b runs the multi-cycle
// burst, truncation and counter-wrap sequences.
// -----------------------------------------------------------------------------
module tb_phase_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance a signals
  logic        a_rst = 1'b1, a_hlt = 1'b0, a_run = 1'b0, a_step = 1'b0, a_bs = 1'b0;
  logic [31:0] a_blen = '0;
  logic        a_cpu, a_mem, a_busy, a_halted;
  logic [0:0]  a_phase;
  logic [31:0] a_cnt;

  // Instance b signals
  logic        b_rst = 1'b1, b_hlt = 1'b0, b_run = 1'b0, b_step = 1'b0, b_bs = 1'b0;
  logic [3:0]  b_blen = '0;
  logic        b_cpu, b_mem, b_busy, b_halted;
  logic [1:0]  b_phase;
  logic [3:0]  b_cnt;

  phase_sequencer u_a (
    .clk(clk), .rst(a_rst), .hlt(a_hlt), .run(a_run), .step(a_step),
    .burst_start(a_bs), .burst_len(a_blen),
    .cpu_en(a_cpu), .mem_en(a_mem), .phase(a_phase),
    .busy(a_busy), .halted(a_halted), .cycle_count(a_cnt)
  );

  phase_sequencer #(
    .DIVISOR(3), .PHASES(4), .CPU_PHASE(0), .MEM_PHASE(2), .CNT_W(4)
  ) u_b (
    .clk(clk), .rst(b_rst), .hlt(b_hlt), .run(b_run), .step(b_step),
    .burst_start(b_bs), .burst_len(b_blen),
    .cpu_en(b_cpu), .mem_en(b_mem), .phase(b_phase),
    .busy(b_busy), .halted(b_halted), .cycle_count(b_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Vector: inputs {rst,hlt,run,step,burst_start}, burst_len,
  //         outputs {cpu_en,mem_en,phase,busy,halted}, cycle_count.
  typedef struct {
    logic [4:0]  in;
    logic [31:0] blen;
    logic [4:0]  out;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic [4:0] in, input int blen,
                             input logic [4:0] out, input int cnt);
    vec_t r;
    r.in   = in;
    r.blen = 32'(blen);
    r.out  = out;
    r.cnt  = 32'(cnt);
    return r;
  endfunction

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  // Drive b with a one-cycle request, then sample until it leaves busy.
  task automatic b_go(input logic st, input logic bs, input logic [3:0] len,
                      input int limit, output int busy_n, output int cpu_n,
                      output int mem_n);
    busy_n = 0; cpu_n = 0; mem_n = 0;
    b_step = st; b_bs = bs; b_blen = len;
    edge_sample();
    b_step = 1'b0; b_bs = 1'b0;
    for (int k = 0; k < limit; k++) begin
      if (!b_busy) break;
      busy_n++;
      if (b_cpu) cpu_n++;
      if (b_mem) mem_n++;
      edge_sample();
    end
    if (b_busy) check("b_go_timeout", 1, 0);
    // Strobe from the final tick is visible in the first idle sample.
    if (b_cpu) cpu_n++;
    if (b_mem) mem_n++;
  endtask

  task automatic b_reset();
    b_rst = 1'b1;
    edge_sample();
    b_rst = 1'b0;
  endtask

  initial begin
    int busy_n, cpu_n, mem_n, k_last_cpu, first_cpu, first_mem, gap_bad;

    // ---------------------------------------------------------------- table
    // Single step
    vecs.push_back(v(5'b10000, 0, 5'b00000, 0));   // reset
    vecs.push_back(v(5'b00010, 0, 5'b00010, 0));   // E0 step -> STEP
    vecs.push_back(v(5'b00010, 0, 5'b00010, 0));   // step while busy: ignored
    vecs.push_back(v(5'b00000, 0, 5'b10110, 0));   // E2 cpu_en, phase 1
    vecs.push_back(v(5'b00000, 0, 5'b00110, 0));
    vecs.push_back(v(5'b00000, 0, 5'b01000, 1));   // E4 mem_en, IDLE, count 1
    vecs.push_back(v(5'b00000, 0, 5'b00000, 1));
    vecs.push_back(v(5'b00000, 0, 5'b00000, 1));
    // Halt raised mid-cycle during RUN
    vecs.push_back(v(5'b00100, 0, 5'b00010, 1));
    vecs.push_back(v(5'b00100, 0, 5'b00010, 1));
    vecs.push_back(v(5'b01100, 0, 5'b10110, 1));
    vecs.push_back(v(5'b01000, 0, 5'b00110, 1));
    vecs.push_back(v(5'b01000, 0, 5'b01001, 2));   // mem_en still fires, HALT
    vecs.push_back(v(5'b00010, 0, 5'b00001, 2));   // sticky
    vecs.push_back(v(5'b00100, 0, 5'b00001, 2));
    vecs.push_back(v(5'b00111, 3, 5'b00001, 2));
    vecs.push_back(v(5'b10000, 0, 5'b00000, 0));   // only rst leaves HALT
    // Zero-length burst ignored
    vecs.push_back(v(5'b00001, 0, 5'b00000, 0));
    vecs.push_back(v(5'b00000, 0, 5'b00000, 0));
    // Halt withdrawn before wrap cancels
    vecs.push_back(v(5'b00010, 0, 5'b00010, 0));
    vecs.push_back(v(5'b01000, 0, 5'b00010, 0));
    vecs.push_back(v(5'b01000, 0, 5'b10110, 0));
    vecs.push_back(v(5'b00000, 0, 5'b00110, 0));
    vecs.push_back(v(5'b00000, 0, 5'b01000, 1));
    vecs.push_back(v(5'b01000, 0, 5'b00001, 1));   // hlt in IDLE -> HALT
    vecs.push_back(v(5'b10000, 0, 5'b00000, 0));
    // Reset during BURST at div=1, phase=1
    vecs.push_back(v(5'b00001, 3, 5'b00010, 0));
    vecs.push_back(v(5'b00000, 0, 5'b00010, 0));
    vecs.push_back(v(5'b00000, 0, 5'b10110, 0));
    vecs.push_back(v(5'b00000, 0, 5'b00110, 0));
    vecs.push_back(v(5'b10000, 0, 5'b00000, 0));   // no stray mem_en
    vecs.push_back(v(5'b00000, 0, 5'b00000, 0));
    vecs.push_back(v(5'b00000, 0, 5'b00000, 0));

    edge_sample();
    b_rst = 1'b0;
    check("b_reset_outputs", {b_cpu, b_mem, b_phase, b_busy, b_halted, b_cnt}, '0);

    foreach (vecs[i]) begin
      {a_rst, a_hlt, a_run, a_step, a_bs} = vecs[i].in;
      a_blen = vecs[i].blen;
      edge_sample();
      check($sformatf("vec%0d_out{cpu,mem,ph,busy,hlt}", i),
            {a_cpu, a_mem, a_phase, a_busy, a_halted}, vecs[i].out);
      check($sformatf("vec%0d_cycle_count", i), a_cnt, vecs[i].cnt);
    end
    {a_rst, a_hlt, a_run, a_step, a_bs} = '0;

    // ------------------------------------------- run high 10 clk then low
    busy_n = 0; cpu_n = 0; mem_n = 0;
    for (int k = 0; k < 100; k++) begin
      a_run = (k < 10);
      edge_sample();
      if (a_cpu) cpu_n++;
      if (a_mem) mem_n++;
      if (a_busy) busy_n++;
      else if (k > 0) break;
    end
    a_run = 1'b0;
    check("run10_cpu_pulses", cpu_n, 3);
    check("run10_mem_pulses", mem_n, 3);
    check("run10_busy_cycles", busy_n, 12);
    check("run10_cycle_count", a_cnt, 3);
    check("run10_phase", a_phase, 0);

    // ------------------------------------------- b: burst of 5
    busy_n = 0; cpu_n = 0; mem_n = 0; gap_bad = 0;
    k_last_cpu = -1; first_cpu = -1; first_mem = -1;
    b_bs = 1'b1; b_blen = 4'd5;
    for (int k = 0; k < 200; k++) begin
      edge_sample();
      b_bs = 1'b0;
      if (b_cpu) begin
        cpu_n++;
        if (first_cpu < 0) first_cpu = k;
        if (k_last_cpu >= 0 && k - k_last_cpu != 12) gap_bad++;
        k_last_cpu = k;
      end
      if (b_mem) begin
        mem_n++;
        if (first_mem < 0) first_mem = k;
      end
      if (b_busy) busy_n++;
      else if (k > 0) break;
    end
    check("burst5_cpu_pulses", cpu_n, 5);
    check("burst5_mem_pulses", mem_n, 5);
    check("burst5_busy_cycles", busy_n, 60);
    check("burst5_cycle_count", b_cnt, 5);
    check("burst5_cpu_gap", gap_bad, 0);
    check("burst5_first_cpu", first_cpu, 3);
    check("burst5_first_mem", first_mem, 9);
    check("burst5_phase", b_phase, 0);

    // ------------------------------------------- b: burst_len 17 -> 4'd1
    b_reset();
    b_go(1'b0, 1'b1, 4'(17), 100, busy_n, cpu_n, mem_n);
    check("burst17_cycle_count", b_cnt, 1);
    check("burst17_busy_cycles", busy_n, 12);
    check("burst17_cpu_pulses", cpu_n, 1);

    // ------------------------------------------- b: counter wrap
    b_reset();
    b_go(1'b0, 1'b1, 4'd15, 400, busy_n, cpu_n, mem_n);
    check("wrap_pre_count", b_cnt, 15);
    check("wrap_pre_busy_cycles", busy_n, 180);
    b_go(1'b1, 1'b0, 4'd0, 100, busy_n, cpu_n, mem_n);
    check("wrap_post_count", b_cnt, 0);
    check("wrap_post_state{busy,halted}", {b_busy, b_halted}, 2'b00);
    check("wrap_post_mem_pulses", mem_n, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
